// File: rtl/fetch_dispatch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fetch_dispatch_unit                                        |
// | Description : Front-end fetch/dispatch. Fetches 16-bit instruction words |
// |               into ir, owns pc (advanced by execution-FSM pc_inc), waits |
// |               for done, then drives a bubble word for one cycle so all   |
// |               execution FSMs return to idle before the next fetch.       |
// |               Optional macro SINGLE_STEP_EN adds a step input that holds |
// |               BUBBLE until step=1.                                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module fetch_dispatch_unit #(
  parameter int          ADDR_W      = 8,
  parameter logic [15:0] BUBBLE_WORD = 16'hF000,
  parameter int          TIMEOUT     = 15
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [15:0]       mem_data,
  input  logic              mem_valid,
  output logic [15:0]       ir,
  input  logic              pc_inc,
  input  logic              done,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              illegal_op
`ifdef SINGLE_STEP_EN
  ,
  input  logic              step
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_EXEC   = 2'd2,
    S_BUBBLE = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] PC_ONE    = ADDR_W'(1);
  localparam logic [7:0]        TMO_LIMIT = 8'(TIMEOUT);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [15:0]         ir_q, ir_d;
  logic [7:0]          tmo_q, tmo_d;
  logic                inc_seen_q, inc_seen_d;
  logic                mem_rd_q, mem_rd_d;
  logic                busy_q, busy_d;
  logic                illegal_q, illegal_d;
  logic [7:0]          tmo_next;
  logic                bubble_release;

`ifdef SINGLE_STEP_EN
  assign bubble_release = step;
`else
  assign bubble_release = 1'b1;
`endif

  // Next-state, pc, ir, timeout and registered-output computation
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    tmo_d      = tmo_q;
    inc_seen_d = inc_seen_q;
    illegal_d  = illegal_q;
    tmo_next   = tmo_q + 8'd1;

    case (state_q)
      S_IDLE: begin
        ir_d    = BUBBLE_WORD;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        ir_d = BUBBLE_WORD;
        if (mem_valid) begin
          ir_d       = mem_data;
          tmo_d      = 8'd0;
          inc_seen_d = 1'b0;
          state_d    = S_EXEC;
        end
      end
      S_EXEC: begin
        tmo_d = tmo_next;
        if (pc_inc) begin
          pc_d       = pc_q + PC_ONE;
          inc_seen_d = 1'b1;
        end
        // done takes priority over a coincident timeout
        if (done) begin
          ir_d    = BUBBLE_WORD;
          state_d = S_BUBBLE;
        end else if (tmo_next >= TMO_LIMIT) begin
          illegal_d = 1'b1;
          // skip the abandoned word only if the FSM never advanced pc itself
          if (!inc_seen_q && !pc_inc) begin
            pc_d = pc_q + PC_ONE;
          end
          ir_d    = BUBBLE_WORD;
          state_d = S_BUBBLE;
        end
      end
      S_BUBBLE: begin
        ir_d = BUBBLE_WORD;
        if (bubble_release) begin
          state_d = S_FETCH;
        end
      end
      default: begin
        ir_d    = BUBBLE_WORD;
        state_d = S_IDLE;
      end
    endcase

    // outputs registered alongside the state they describe
    mem_rd_d = (state_d == S_FETCH);
    busy_d   = (state_d == S_FETCH) || (state_d == S_EXEC);
  end

  // State and output registers, asynchronously reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      ir_q       <= BUBBLE_WORD;
      tmo_q      <= 8'd0;
      inc_seen_q <= 1'b0;
      mem_rd_q   <= 1'b0;
      busy_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      tmo_q      <= tmo_d;
      inc_seen_q <= inc_seen_d;
      mem_rd_q   <= mem_rd_d;
      busy_q     <= busy_d;
      illegal_q  <= illegal_d;
    end
  end

  assign mem_addr   = pc_q;
  assign pc         = pc_q;
  assign ir         = ir_q;
  assign mem_rd     = mem_rd_q;
  assign busy       = busy_q;
  assign illegal_op = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_dispatch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_fetch_dispatch_unit                                     |
// | Description : Directed-vector bench for fetch_dispatch_unit.             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_fetch_dispatch_unit;

  logic        clk;
  logic        rst;
  logic [7:0]  mem_addr;
  logic        mem_rd;
  logic [15:0] mem_data;
  logic        mem_valid;
  logic [15:0] ir;
  logic        pc_inc;
  logic        done;
  logic [7:0]  pc;
  logic        busy;
  logic        illegal_op;
`ifdef SINGLE_STEP_EN
  logic        step;
`endif

  int n_vec = 0;
  int n_bad = 0;

  fetch_dispatch_unit #(
    .ADDR_W      (8),
    .BUBBLE_WORD (16'hF000),
    .TIMEOUT     (15)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .mem_valid  (mem_valid),
    .ir         (ir),
    .pc_inc     (pc_inc),
    .done       (done),
    .pc         (pc),
    .busy       (busy),
    .illegal_op (illegal_op)
`ifdef SINGLE_STEP_EN
    ,
    .step       (step)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        valid;
    logic [15:0] data;
    logic        inc;
    logic        dn;
    logic        e_rd;
    logic [7:0]  e_pc;
    logic [15:0] e_ir;
    logic        e_busy;
    logic        e_ill;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic v, input logic [15:0] d,
                              input logic inc, input logic dn, input logic e_rd,
                              input logic [7:0] e_pc, input logic [15:0] e_ir,
                              input logic e_busy, input logic e_ill);
    vec_t x;
    x.rst = r; x.valid = v; x.data = d; x.inc = inc; x.dn = dn;
    x.e_rd = e_rd; x.e_pc = e_pc; x.e_ir = e_ir; x.e_busy = e_busy; x.e_ill = e_ill;
    tbl.push_back(x);
  endfunction

  task automatic drive(input logic r, input logic v, input logic [15:0] d,
                       input logic inc, input logic dn);
    rst = r; mem_valid = v; mem_data = d; pc_inc = inc; done = dn;
  endtask

  // advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic e_rd, input logic [7:0] e_pc,
                     input logic [15:0] e_ir, input logic e_busy, input logic e_ill);
    n_vec++;
    if (mem_rd !== e_rd || pc !== e_pc || mem_addr !== e_pc || ir !== e_ir ||
        busy !== e_busy || illegal_op !== e_ill) begin
      n_bad++;
      $display("FAIL %s: got rd=%b addr=%h pc=%h ir=%h busy=%b ill=%b ; want rd=%b pc=%h ir=%h busy=%b ill=%b",
               name, mem_rd, mem_addr, pc, ir, busy, illegal_op, e_rd, e_pc, e_ir, e_busy, e_ill);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] m_pc;
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
`ifdef SINGLE_STEP_EN
    step = 1'b1;
`endif

    // ---------------- vector table ----------------
    add(1,0,16'h0000,0,0, 0,8'h00,16'hF000,0,0);   // reset state
    add(0,0,16'h0000,0,0, 1,8'h00,16'hF000,1,0);   // IDLE -> FETCH
    add(0,1,16'h6000,0,0, 0,8'h00,16'h6000,1,0);   // zero-wait fetch of MOV
    add(0,0,16'h0000,0,0, 0,8'h00,16'h6000,1,0);
    add(0,0,16'h0000,1,0, 0,8'h01,16'h6000,1,0);   // PC_inc pulse
    add(0,0,16'h0000,0,0, 0,8'h01,16'h6000,1,0);
    add(0,0,16'h0000,0,1, 0,8'h01,16'hF000,0,0);   // done -> BUBBLE
    add(0,0,16'h0000,0,0, 1,8'h01,16'hF000,1,0);   // next fetch at 1
    add(0,0,16'h0000,0,0, 1,8'h01,16'hF000,1,0);   // memory wait
    add(0,0,16'h0000,0,0, 1,8'h01,16'hF000,1,0);
    add(0,0,16'h0000,0,0, 1,8'h01,16'hF000,1,0);
    add(0,1,16'h6000,0,0, 0,8'h01,16'h6000,1,0);   // loads on 4th FETCH cycle
    add(0,1,16'h1234,1,0, 0,8'h02,16'h6000,1,0);   // mem_valid in EXEC ignored
    add(0,0,16'h0000,1,1, 0,8'h03,16'hF000,0,0);   // pc_inc + done together
    add(0,0,16'h0000,1,1, 1,8'h03,16'hF000,1,0);   // pc_inc/done in BUBBLE ignored
    add(0,1,16'h6000,0,0, 0,8'h03,16'h6000,1,0);
    add(0,0,16'h0000,1,0, 0,8'h04,16'h6000,1,0);   // two pulses -> two increments
    add(0,0,16'h0000,1,0, 0,8'h05,16'h6000,1,0);
    add(0,0,16'h0000,0,1, 0,8'h05,16'hF000,0,0);
    add(0,0,16'h0000,0,0, 1,8'h05,16'hF000,1,0);
    add(0,1,16'h9000,0,0, 0,8'h05,16'h9000,1,0);   // unhandled opcode
    for (int k = 0; k < 14; k++)
      add(0,0,16'h0000,0,0, 0,8'h05,16'h9000,1,0);
    add(0,0,16'h0000,0,0, 0,8'h06,16'hF000,0,1);   // 15th EXEC cycle: timeout
    add(0,0,16'h0000,0,0, 1,8'h06,16'hF000,1,1);   // fetch resumes at 6
    add(0,1,16'h6000,0,0, 0,8'h06,16'h6000,1,1);
    add(0,0,16'h0000,1,1, 0,8'h07,16'hF000,0,1);   // illegal_op sticky
    add(0,0,16'h0000,0,0, 1,8'h07,16'hF000,1,1);
    add(1,0,16'h0000,0,0, 0,8'h00,16'hF000,0,0);   // only reset clears it
    add(0,0,16'h0000,0,0, 1,8'h00,16'hF000,1,0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].valid, tbl[i].data, tbl[i].inc, tbl[i].dn);
      cyc();
      chk($sformatf("vec%0d", i), tbl[i].e_rd, tbl[i].e_pc, tbl[i].e_ir, tbl[i].e_busy, tbl[i].e_ill);
    end

    // ---------------- asynchronous reset in 2nd EXEC cycle at pc=3 ----------------
    drive(0,1,16'h6000,0,0); cyc();
    drive(0,0,16'h0000,1,0); cyc();
    drive(0,0,16'h0000,1,0); cyc();
    drive(0,0,16'h0000,1,1); cyc();                // pc=3, BUBBLE
    drive(0,0,16'h0000,0,0); cyc();                // FETCH
    drive(0,1,16'h6000,0,0); cyc();                // 1st EXEC cycle
    drive(0,0,16'h0000,0,0); cyc();                // 2nd EXEC cycle
    chk("pre_async_rst", 0, 8'h03, 16'h6000, 1, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", 0, 8'h00, 16'hF000, 0, 0);
    cyc();
    rst = 1'b0;
    cyc();                                          // IDLE -> FETCH

    // ---------------- pc wrap; done coincident with timeout ----------------
    m_pc = 8'h00;
    for (int n = 0; n < 17; n++) begin
      drive(0,1,16'h6000,0,0); cyc();
      for (int j = 0; j < 15; j++) begin
        drive(0,0,16'h0000,1,(j == 14)); cyc();
        m_pc = m_pc + 8'h01;
      end
      chk($sformatf("done_vs_tmo%0d", n), 0, m_pc, 16'hF000, 0, 0);
      drive(0,0,16'h0000,0,0); cyc();
    end
    drive(0,1,16'h6000,0,0); cyc();
    chk("pc_ff", 0, 8'hFF, 16'h6000, 1, 0);
    drive(0,0,16'h0000,1,1); cyc();
    chk("pc_wrap", 0, 8'h00, 16'hF000, 0, 0);
    drive(0,0,16'h0000,0,0); cyc();
    chk("fetch_after_wrap", 1, 8'h00, 16'hF000, 1, 0);

`ifdef SINGLE_STEP_EN
    // ---------------- single step: BUBBLE holds until step ----------------
    step = 1'b0;
    drive(1,0,16'h0000,0,0); cyc();
    drive(0,0,16'h0000,0,0); cyc();                // FETCH
    drive(0,1,16'h6000,0,0); cyc();                // EXEC
    drive(0,0,16'h0000,1,1); cyc();                // BUBBLE, pc=1
    drive(0,0,16'h0000,0,0);
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk($sformatf("step_hold%0d", k), 0, 8'h01, 16'hF000, 0, 0);
    end
    step = 1'b1; cyc();
    chk("step_fetch", 1, 8'h01, 16'hF000, 1, 0);
    step = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
